// File: rtl/dm_master_arb_pkg.sv
// Shared types for the system-bus master arbiter: FSM state encoding and
// the helper that sizes port-index signals.
package dm;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  // Width of a port index; never below one bit so a 1-port corner still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_master_arb_if.sv
// Bundle of requester-side and downstream-bus signals for dm_master_arb.
// slave: the arbiter's view; master: the environment (requesters + bus).
interface dm_master_arb_if #(
  parameter int unsigned NrPorts  = 2,
  parameter int unsigned BusWidth = 32
);
  logic [NrPorts-1:0]                  port_req_i;
  logic [NrPorts-1:0]                  port_we_i;
  logic [NrPorts-1:0][BusWidth-1:0]    port_addr_i;
  logic [NrPorts-1:0][BusWidth-1:0]    port_wdata_i;
  logic [NrPorts-1:0][BusWidth/8-1:0]  port_be_i;
  logic [NrPorts-1:0]                  port_gnt_o;
  logic [NrPorts-1:0]                  port_r_valid_o;
  logic [NrPorts-1:0]                  port_err_o;
  logic [BusWidth-1:0]                 port_r_rdata_o;

  logic                                master_req_o;
  logic [BusWidth-1:0]                 master_add_o;
  logic                                master_we_o;
  logic [BusWidth-1:0]                 master_wdata_o;
  logic [BusWidth/8-1:0]               master_be_o;
  logic                                master_gnt_i;
  logic                                master_r_valid_i;
  logic [BusWidth-1:0]                 master_r_rdata_i;

  modport slave (
    input  port_req_i, port_we_i, port_addr_i, port_wdata_i, port_be_i,
    input  master_gnt_i, master_r_valid_i, master_r_rdata_i,
    output port_gnt_o, port_r_valid_o, port_err_o, port_r_rdata_o,
    output master_req_o, master_add_o, master_we_o, master_wdata_o, master_be_o
  );

  modport master (
    output port_req_i, port_we_i, port_addr_i, port_wdata_i, port_be_i,
    output master_gnt_i, master_r_valid_i, master_r_rdata_i,
    input  port_gnt_o, port_r_valid_o, port_err_o, port_r_rdata_o,
    input  master_req_o, master_add_o, master_we_o, master_wdata_o, master_be_o
  );
endinterface

// File: rtl/dm_master_arb_rr_arbiter.sv
// Round-robin pointer plus rotated priority select: the first requester at or
// after the pointer wins; the pointer moves past a port once it is granted.
module dm_rr_arbiter #(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned IdxW    = dm::idx_width(NrPorts)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrPorts-1:0] req,
  input  logic               advance,
  input  logic [IdxW-1:0]    adv_idx,
  output logic [IdxW-1:0]    winner,
  output logic               any_req
);
  logic [IdxW-1:0] ptr_reg, ptr_next;
  logic [IdxW-1:0] cand [NrPorts];

  // cand[gi] is the port that sits gi places after the pointer, modulo NrPorts.
  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_rot
    logic [IdxW:0] sum;
    assign sum       = {1'b0, ptr_reg} + (IdxW+1)'(gi);
    assign cand[gi]  = (sum >= (IdxW+1)'(NrPorts)) ? IdxW'(sum - (IdxW+1)'(NrPorts))
                                                   : sum[IdxW-1:0];
  end

  always_comb begin
    winner = ptr_reg;
    for (int i = NrPorts - 1; i >= 0; i--) begin
      if (req[cand[i]]) winner = cand[i];
    end
  end

  assign any_req  = |req;
  assign ptr_next = (adv_idx == IdxW'(NrPorts - 1)) ? '0 : adv_idx + IdxW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr_reg <= '0;
    else if (advance) ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/dm_master_arb.sv
// Shares one system-bus master port among NrPorts requesters, one transaction
// at a time. Optional response timeout: define DM_MASTER_ARB_TIMEOUT_EN.
module dm_master_arb
  import dm::*;
#(
  parameter int unsigned NrPorts       = 2,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input logic           clk_i,
  input logic           rst_i,
  dm_master_arb_if.slave bus
);
  localparam int unsigned IdxW = idx_width(NrPorts);
  localparam int unsigned BeW  = BusWidth / 8;

  if (NrPorts < 2 || NrPorts > 8) begin : g_bad_ports
    $error("dm_master_arb: NrPorts must be 2..8");
  end
  if (BusWidth != 32 && BusWidth != 64) begin : g_bad_width
    $error("dm_master_arb: BusWidth must be 32 or 64");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("dm_master_arb: TimeoutCycles must be at least 2");
  end

  state_e              state_reg, state_next;
  logic [IdxW-1:0]     sel_reg, sel_next, winner, adv_idx;
  logic                any_req, advance, capture, timeout_hit;
  logic [BusWidth-1:0] addr_reg, wdata_reg;
  logic                we_reg;
  logic [BeW-1:0]      be_reg;
  logic [NrPorts-1:0]  gnt_vec, rvalid_vec, err_vec;
  logic [BusWidth-1:0] rdata_mux, add_mux, wdata_mux;
  logic                req_mux, we_mux;
  logic [BeW-1:0]      be_mux;

  dm_rr_arbiter #(.NrPorts(NrPorts), .IdxW(IdxW)) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (bus.port_req_i),
    .advance (advance),
    .adv_idx (adv_idx),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef DM_MASTER_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                cnt_reg <= '0;
    else if (state_reg != RSP) cnt_reg <= '0;
    else                      cnt_reg <= cnt_reg + CntW'(1);
  end

  assign timeout_hit = (state_reg == RSP) && (cnt_reg == CntW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    adv_idx    = sel_reg;
    advance    = 1'b0;
    capture    = 1'b0;
    req_mux    = 1'b0;
    add_mux    = '0;
    we_mux     = 1'b0;
    wdata_mux  = '0;
    be_mux     = '0;
    gnt_vec    = '0;
    rvalid_vec = '0;
    err_vec    = '0;
    rdata_mux  = '0;
    case (state_reg)
      IDLE: begin
        // Zero-latency path: the winner's fields go straight to the bus; outputs stay quiet in reset.
        if (any_req && !rst_i) begin
          req_mux   = 1'b1;
          add_mux   = bus.port_addr_i[winner];
          we_mux    = bus.port_we_i[winner];
          wdata_mux = bus.port_wdata_i[winner];
          be_mux    = bus.port_be_i[winner];
          sel_next  = winner;
          adv_idx   = winner;
          if (bus.master_gnt_i) begin
            gnt_vec[winner] = 1'b1;
            advance         = 1'b1;
            state_next      = RSP;
          end else begin
            capture    = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        req_mux          = 1'b1;
        add_mux          = addr_reg;
        we_mux           = we_reg;
        wdata_mux        = wdata_reg;
        be_mux           = be_reg;
        gnt_vec[sel_reg] = bus.master_gnt_i;
        if (bus.master_gnt_i) begin
          advance    = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        // A real response beats a timeout landing in the same cycle.
        if (bus.master_r_valid_i) begin
          rvalid_vec[sel_reg] = 1'b1;
          rdata_mux           = bus.master_r_rdata_i;
          state_next          = IDLE;
        end else if (timeout_hit) begin
          rvalid_vec[sel_reg] = 1'b1;
          err_vec[sel_reg]    = 1'b1;
          state_next          = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      if (capture) begin
        addr_reg  <= bus.port_addr_i[winner];
        we_reg    <= bus.port_we_i[winner];
        wdata_reg <= bus.port_wdata_i[winner];
        be_reg    <= bus.port_be_i[winner];
      end
    end
  end

  assign bus.port_gnt_o     = gnt_vec;
  assign bus.port_r_valid_o = rvalid_vec;
  assign bus.port_err_o     = err_vec;
  assign bus.port_r_rdata_o = rdata_mux;
  assign bus.master_req_o   = req_mux;
  assign bus.master_add_o   = add_mux;
  assign bus.master_we_o    = we_mux;
  assign bus.master_wdata_o = wdata_mux;
  assign bus.master_be_o    = be_mux;
endmodule

// File: tb/tb_dm_master_arb.sv
// Scoreboard bench for dm_master_arb: a 2-port and a 3-port instance share one
// stimulus set; sel_b picks which one is active. Timeout cases need DM_MASTER_ARB_TIMEOUT_EN.
module tb_dm_master_arb;
  import dm::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             sel_b;
  logic [2:0]       req, we;
  logic [2:0][31:0] addr, wdata;
  logic [2:0][3:0]  be;
  logic             gnt, rvalid;
  logic [31:0]      rdata_in;

  dm_master_arb_if #(.NrPorts(2), .BusWidth(32)) bus_a ();
  dm_master_arb_if #(.NrPorts(3), .BusWidth(32)) bus_b ();

  dm_master_arb #(.NrPorts(2), .BusWidth(32), .TimeoutCycles(16)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (bus_a)
  );
  dm_master_arb #(.NrPorts(3), .BusWidth(32), .TimeoutCycles(16)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (bus_b)
  );

  assign bus_a.port_req_i       = sel_b ? 2'b00 : req[1:0];
  assign bus_a.port_we_i        = we[1:0];
  assign bus_a.port_addr_i      = addr[1:0];
  assign bus_a.port_wdata_i     = wdata[1:0];
  assign bus_a.port_be_i        = be[1:0];
  assign bus_a.master_gnt_i     = gnt & ~sel_b;
  assign bus_a.master_r_valid_i = rvalid & ~sel_b;
  assign bus_a.master_r_rdata_i = rdata_in;

  assign bus_b.port_req_i       = sel_b ? req : 3'b000;
  assign bus_b.port_we_i        = we;
  assign bus_b.port_addr_i      = addr;
  assign bus_b.port_wdata_i     = wdata;
  assign bus_b.port_be_i        = be;
  assign bus_b.master_gnt_i     = gnt & sel_b;
  assign bus_b.master_r_valid_i = rvalid & sel_b;
  assign bus_b.master_r_rdata_i = rdata_in;

  logic [2:0]  o_gnt, o_rv, o_err;
  logic [31:0] o_rdata, o_add;
  logic        o_req, o_we;
  assign o_gnt   = sel_b ? bus_b.port_gnt_o     : {1'b0, bus_a.port_gnt_o};
  assign o_rv    = sel_b ? bus_b.port_r_valid_o : {1'b0, bus_a.port_r_valid_o};
  assign o_err   = sel_b ? bus_b.port_err_o     : {1'b0, bus_a.port_err_o};
  assign o_rdata = sel_b ? bus_b.port_r_rdata_o : bus_a.port_r_rdata_o;
  assign o_add   = sel_b ? bus_b.master_add_o   : bus_a.master_add_o;
  assign o_req   = sel_b ? bus_b.master_req_o   : bus_a.master_req_o;
  assign o_we    = sel_b ? bus_b.master_we_o    : bus_a.master_we_o;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_gnt[$];
  rsp_t exp_rsp[$];
  int   pend[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot(input logic [2:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        r = i;
        c++;
      end
    end
    return (c == 1) ? r : -1;
  endfunction

  function automatic rsp_t pop_rsp();
    rsp_t e;
    e.port = -2; e.data = '0; e.err = 1'b0;
    if (exp_rsp.size() > 0) e = exp_rsp.pop_front();
    return e;
  endfunction

  // One downstream transaction: called at posedge+1. rsp_dly < 0 leaves the
  // response to the caller and returns at posedge+2 of the first RSP cycle.
  task automatic serve(input int gnt_dly, input int rsp_dly, input logic [31:0] rdata,
                       input int late_port);
    int          n = 0;
    int          p;
    int          exp_p;
    logic [31:0] a0;
    logic        w0;
    rsp_t        e;
    #1;
    while (!o_req) begin
      if (n >= 50) begin
        check("req_wait", 64'd0, 64'd1);
        return;
      end
      n++;
      @(posedge clk); #2;
    end
    a0 = o_add;
    w0 = o_we;
    for (int k = 0; k < gnt_dly; k++) begin
      @(posedge clk); #1;
      if (k == 1 && late_port >= 0) begin
        req[late_port] = 1'b1;
        pend[late_port]++;
      end
      rvalid = (k == 2);
      #1;
      check("add_hold", o_add, a0);
      check("we_hold", o_we, w0);
      check("req_hold", o_req, 1'b1);
      check("early_gnt", o_gnt, 3'b000);
      check("req_spurious_rv", o_rv, 3'b000);
    end
    rvalid = 1'b0;
    gnt    = 1'b1;
    #1;
    p     = onehot(o_gnt);
    exp_p = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : -2;
    check("gnt_port", p, exp_p);
    if (p >= 0) begin
      check("gnt_add", o_add, addr[p]);
      check("gnt_we", o_we, we[p]);
    end
    $display("grant port %0d addr %h we %0d", p, o_add, o_we);
    @(posedge clk); #1;
    gnt = 1'b0;
    if (p >= 0) begin
      pend[p]--;
      if (pend[p] <= 0) req[p] = 1'b0;
    end
    #1;
    check("rsp_no_req", o_req, 1'b0);
    if (rsp_dly < 0) return;
    repeat (rsp_dly - 1) begin
      @(posedge clk); #1;
    end
    rvalid   = 1'b1;
    rdata_in = rdata;
    #1;
    e = pop_rsp();
    check("rv_port", onehot(o_rv), e.port);
    check("rdata", o_rdata, e.data);
    check("err", |o_err, e.err);
    $display("response port %0d rdata %h err %0d", onehot(o_rv), o_rdata, |o_err);
    @(posedge clk); #1;
    rvalid   = 1'b0;
    rdata_in = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    rsp_t e;
    rst = 1'b1; sel_b = 1'b0; gnt = 1'b0;
    rvalid = 1'b1; rdata_in = 32'hFFFF_FFFF;
    for (int p = 0; p < 3; p++) begin
      addr[p]  = 32'h1000_0000 + 32'(p) * 32'h100;
      wdata[p] = 32'hA000_0000 + 32'(p);
      be[p]    = 4'hF;
    end
    we   = 3'b010;
    req  = 3'b011;
    pend = '{2, 1, 0};

    // Reset with requests pending and a stray response on the bus.
    repeat (2) @(posedge clk);
    #2;
    check("rst_mreq", o_req, 1'b0);
    check("rst_gnt", o_gnt, 3'b000);
    check("rst_rv", o_rv, 3'b000);
    check("rst_add", o_add, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_state", dut_a.state_reg, IDLE);
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b0; rdata_in = '0;

    // Both ports request at release; immediate grant, response 2 cycles later.
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0);
    e = '{0, 32'h1111_0000, 1'b0}; exp_rsp.push_back(e);
    e = '{1, 32'h2222_0000, 1'b0}; exp_rsp.push_back(e);
    e = '{0, 32'h3333_0000, 1'b0}; exp_rsp.push_back(e);
    serve(0, 2, 32'h1111_0000, -1);
    serve(0, 2, 32'h2222_0000, -1);
    serve(0, 2, 32'h3333_0000, -1);

    // Stray response while idle.
    rvalid = 1'b1; rdata_in = 32'h5555_5555;
    #1;
    check("idle_spurious_rv", o_rv, 3'b000);
    check("idle_spurious_rdata", o_rdata, 32'h0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata_in = '0;

    // Port1 read with delayed grant; port0 arrives meanwhile and must wait.
    we[1] = 1'b0; req[1] = 1'b1; pend[1] = 1;
    exp_gnt.push_back(1); exp_gnt.push_back(0);
    e = '{1, 32'h1234_5678, 1'b0}; exp_rsp.push_back(e);
    e = '{0, 32'hDEAD_BEEF, 1'b0}; exp_rsp.push_back(e);
    serve(5, 2, 32'h1234_5678, 0);
    serve(0, 1, 32'hDEAD_BEEF, -1);

`ifdef DM_MASTER_ARB_TIMEOUT_EN
    // No response: error pulse 16 cycles after grant, then normal traffic.
    req[0] = 1'b1; pend[0] = 1;
    exp_gnt.push_back(0);
    serve(0, -1, 32'h0, -1);
    k = 1;
    while (o_rv == 3'b000 && k <= 40) begin
      @(posedge clk); #2;
      k++;
    end
    check("to_cycles", k, 16);
    check("to_rv_port", onehot(o_rv), 0);
    check("to_err_port", onehot(o_err), 0);
    check("to_rdata", o_rdata, 32'h0);
    $display("timeout port %0d after %0d cycles", onehot(o_err), k);
    @(posedge clk); #2;
    check("to_err_clear", o_err, 3'b000);
    #1;
    req[0] = 1'b1; pend[0] = 1;
    exp_gnt.push_back(0);
    e = '{0, 32'h0BAD_F00D, 1'b0}; exp_rsp.push_back(e);
    @(posedge clk); #1;
    serve(0, 2, 32'h0BAD_F00D, -1);
`endif

    // Reset during RSP abandons the transaction.
    req[0] = 1'b1; pend[0] = 1;
    exp_gnt.push_back(0);
    serve(0, -1, 32'h0, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_state", dut_a.state_reg, IDLE);
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; rdata_in = 32'h7777_7777;
    #1;
    check("midrst_rv", o_rv, 3'b000);
    check("midrst_rdata", o_rdata, 32'h0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata_in = '0;
    #1;
    check("midrst_state_after", dut_a.state_reg, IDLE);
    check("midrst_mreq", o_req, 1'b0);
    $display("reset in RSP abandoned transaction");

    // Three-port instance: port2 alone, then all ports -> 2,0,1,2.
    @(posedge clk); #1;
    sel_b = 1'b1;
    req[2] = 1'b1; pend[2] = 1;
    exp_gnt.push_back(2);
    e = '{2, 32'hC000_0002, 1'b0}; exp_rsp.push_back(e);
    serve(0, 2, 32'hC000_0002, -1);
    req  = 3'b111;
    pend = '{1, 1, 1};
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    for (int p = 0; p < 3; p++) begin
      e = '{p, 32'hD000_0000 + 32'(p), 1'b0};
      exp_rsp.push_back(e);
    end
    for (int p = 0; p < 3; p++) serve(0, 2, 32'hD000_0000 + 32'(p), -1);

    check("gnt_queue_drained", exp_gnt.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_master_arb.md
DM_MASTER_ARB -- requirements
Module: dm_master_arb

Interface
REQ-001 Parameter NrPorts, default 2, SHALL set the number of requesters sharing the system-bus master port (range 2..8).
REQ-002 Parameter BusWidth, default 32, SHALL set the address/data width (32 or 64 only).
REQ-003 Parameter TimeoutCycles, default 1024, SHALL set the response timeout in cycles (used only with DM_MASTER_ARB_TIMEOUT_EN).
REQ-004 clk_i  in  1  clock; the only clock.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 port_req_i / port_we_i  in  NrPorts  per-port request / write-enable.
REQ-007 port_addr_i / port_wdata_i  in  NrPorts x BusWidth  per-port address / write data.
REQ-008 port_be_i  in  NrPorts x BusWidth/8  per-port byte enables.
REQ-009 port_gnt_o / port_r_valid_o / port_err_o  out  NrPorts  per-port grant / response valid / timeout error.
REQ-010 port_r_rdata_o  out  BusWidth  read data, shared by all ports.
REQ-011 master_req_o, master_add_o, master_we_o, master_wdata_o, master_be_o  out  1/BusWidth/1/BusWidth/BusWidth/8  downstream request.
REQ-012 master_gnt_i, master_r_valid_i, master_r_rdata_i  in  1/1/BusWidth  downstream grant and response.

Function
REQ-013 FSM states SHALL be IDLE, REQ, RSP.
REQ-014 IDLE: when any port_req_i is high, the winner SHALL be selected round-robin, starting from the port after the last granted port; go to REQ in the same cycle that master_req_o rises.
REQ-015 IDLE SHALL drive master_req_o combinationally from the winner's port_req_i, giving zero-cycle request latency.
REQ-016 REQ: the selected port index and its request fields SHALL be held (no re-arbitration) until master_gnt_i.
REQ-017 master_gnt_i SHALL be forwarded combinationally to port_gnt_o of the selected port only; other port_gnt_o stay 0.
REQ-018 On the grant cycle, the FSM SHALL go to RSP, and the round-robin pointer SHALL advance to selected+1, wrapping from NrPorts-1 to 0.
REQ-019 RSP: master_req_o SHALL be 0; at most one outstanding transaction.
REQ-020 In RSP, master_r_valid_i SHALL be routed to port_r_valid_o of the owning port, with port_r_rdata_o = master_r_rdata_i.
REQ-021 The FSM SHALL then return to IDLE, and a new arbitration MAY start in the following cycle.
REQ-022 A response SHALL be generated for writes as well as reads.
REQ-023 If master_r_valid_i is asserted in IDLE or REQ (spurious), it SHALL be ignored.
REQ-024 A requester dropping port_req_i while in REQ is a protocol violation; the arbiter SHALL keep master_req_o asserted until grant.
REQ-025 For simultaneous requests from all ports, each port SHALL be granted exactly once per NrPorts grants.

Reset
REQ-026 While rst_i is high: state IDLE, pointer 0, and all outputs 0, including port_r_rdata_o and master_add_o.
REQ-027 Reset asserted mid-transaction SHALL abandon it; no response is forwarded after release.

Configuration
REQ-028 With DM_MASTER_ARB_TIMEOUT_EN defined, a counter SHALL run in RSP.
REQ-029 When the counter reaches TimeoutCycles-1 without a response, the owning port SHALL receive one-cycle port_r_valid_o=1 and port_err_o=1, with rdata 0, and the FSM SHALL return to IDLE.
REQ-030 Under DM_MASTER_ARB_TIMEOUT_EN, a late response SHALL be dropped; when the timeout cycle and master_r_valid_i coincide, the valid response SHALL win.
REQ-031 Without DM_MASTER_ARB_TIMEOUT_EN, no counter SHALL exist, port_err_o SHALL be tied 0, and RSP SHALL wait indefinitely.

Structure
REQ-032 The state enum and the port-index width ($clog2(NrPorts)) SHALL live in package dm.
REQ-033 A sub-module dm_rr_arbiter (round-robin pointer plus priority select) SHALL be instantiated once.

Verification
REQ-034 NrPorts=2, both ports request at reset release, master_gnt_i immediate, r_valid 2 cycles later: grants SHALL go to port0, then port1, then port0.
REQ-035 Port1 read with master_gnt_i delayed 5 cycles: master_add_o/we SHALL stay stable, port0's request arriving meanwhile SHALL be deferred until after the port1 response.
REQ-036 Port0 read of rdata 0xDEADBEEF: port_r_valid_o[0]=1 and port_r_rdata_o=0xDEADBEEF in the master_r_valid_i cycle, and port_r_valid_o[1]=0.
REQ-037 With DM_MASTER_ARB_TIMEOUT_EN and TimeoutCycles=16, no response: port_err_o SHALL pulse 16 cycles after the grant, then the next request SHALL proceed normally.
REQ-038 rst_i pulsed while in RSP, with master_r_valid_i arriving afterwards: no port_r_valid_o SHALL occur, and the state SHALL be IDLE.
REQ-039 NrPorts=3, port2 only, then all ports: the pointer SHALL wrap and grant order SHALL be 2, 0, 1, 2.
